// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - 4-digit common-anode 7-seg scan driver with blanking and frame-synchronous update
//
// Purpose:
//   Scans a 16-bit hex value across a 4-digit common-anode display. Each digit
//   gets one slot of REFRESH_DIV cycles. The first BLANK_CYCLES cycles of a slot
//   keep every anode off to prevent ghosting; the remaining cycles light that digit.
//   The selected nibble is sent to an external hex-to-7seg decoder. The decoder's
//   active-low pattern returns on sseg_in and is merged with the decimal point.
//   New values are staged in a pending register. They reach the display register
//   only at the frame boundary (digit 3 -> 0 wrap), so a frame never tears.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   value_in   in   16  value to display, nibble k -> digit k
//   load       in   1   capture value_in into the pending register
//   dp_in      in   4   decimal point per digit, active-high, sampled live
//   sseg_in    in   8   active-low decoder pattern (bit7 = DP)
//   digit_out  out  4   nibble of the current digit, to the decoder
//   an_out     out  4   active-low anode enables
//   sseg_out   out  8   active-low segments + DP to the display
//   frame_tick out  1   one-cycle pulse in the first cycle that shows a new value
//
// Configuration macro:
//   SSEG_LEADING_ZERO_BLANK_EN - when defined, leading-zero digits 1..3 stay dark
//   unless their decimal point is set.

module sseg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [7:0]  sseg_in,
  output logic [3:0]  digit_out,
  output logic [3:0]  an_out,
  output logic [7:0]  sseg_out,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // A new slot starts in ON directly when the blank phase is disabled.
  localparam logic [0:0] SLOT_START = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [0:0]       state_q, state_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [15:0]      disp_q, disp_d;
  logic             frame_tick_q, frame_tick_d;

  logic slot_end;
  logic frame_end;
  logic suppress;

  // div_cnt counts the whole slot, across both the blank and the lit phase.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    state_d   = state_q;
    slot_end  = (state_q == ST_ON) && (div_cnt_q == DIV_LAST);
    frame_end = slot_end && (idx_q == 2'd3);

    if (state_q == ST_BLANK && div_cnt_q == BLANK_LAST) begin
      state_d = ST_ON;
    end
    if (slot_end) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
      state_d   = SLOT_START;
    end
  end

  // The display register only changes at the frame boundary. A load that
  // coincides with the boundary bypasses the pending register.
  always_comb begin
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    disp_d       = disp_q;
    frame_tick_d = 1'b0;

    if (frame_end) begin
      if (load) begin
        disp_d       = value_in;
        pend_vld_d   = 1'b0;
        frame_tick_d = 1'b1;
      end else if (pend_vld_q) begin
        disp_d       = pend_q;
        pend_vld_d   = 1'b0;
        frame_tick_d = 1'b1;
      end
    end else if (load) begin
      pend_d     = value_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      pend_q       <= 16'h0000;
      pend_vld_q   <= 1'b0;
      disp_q       <= 16'h0000;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      disp_q       <= disp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    suppress = 1'b0;
    case (idx_q)
      2'd1:    suppress = (disp_q[15:4]  == 12'h000);
      2'd2:    suppress = (disp_q[15:8]  == 8'h00);
      2'd3:    suppress = (disp_q[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase
    if (dp_in[idx_q]) begin
      suppress = 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // The decoder input is driven during blank too, so its output has settled
  // by the time the anode turns on.
  assign digit_out  = disp_q[{idx_q, 2'b00} +: 4];
  assign frame_tick = frame_tick_q;

  // The segment path is combinational from sseg_in so the external decoder
  // adds no latency.
  always_comb begin
    an_out   = 4'b1111;
    sseg_out = 8'hFF;
    if (state_q == ST_ON && !suppress) begin
      an_out   = ~(4'b0001 << idx_q);
      sseg_out = {sseg_in[7] & ~dp_in[idx_q], sseg_in[6:0]};
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - self-checking bench for sseg_scan_driver

module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [7:0]  sseg_in;
  logic [3:0]  digit_out;
  logic [3:0]  an_out;
  logic [7:0]  sseg_out;
  logic        frame_tick;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: absolute cycle count since reset release plus the
  // displayed/pending values. Slot, digit and phase follow from arithmetic on t.
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_tick;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  sseg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .dp_in      (dp_in),
    .sseg_in    (sseg_in),
    .digit_out  (digit_out),
    .an_out     (an_out),
    .sseg_out   (sseg_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h at t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_disp = 16'h0000;
    m_pend = 16'h0000;
    m_pv   = 0;
    m_tick = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, then
  // advance the model across the rising edge.
  task automatic cycle(input bit ld, input logic [15:0] val, input logic [3:0] dp, input logic [7:0] sg);
    int          idx;
    int          pos;
    bit          supp;
    logic [3:0]  e_an;
    logic [7:0]  e_sg;
    logic [15:0] e_dig;
    load     = ld;
    value_in = val;
    dp_in    = dp;
    sseg_in  = sg;
    #1;
    idx  = (t / DIV) % 4;
    pos  = t % DIV;
    supp = 0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (idx > 0 && (m_disp >> (4 * idx)) == 16'h0000 && !dp[idx]) supp = 1;
`endif
    e_an  = (pos < BLANK || supp) ? 4'b1111 : ~(4'b0001 << idx);
    e_sg  = (pos < BLANK) ? 8'hFF : {sg[7] & ~dp[idx], sg[6:0]};
    e_dig = (m_disp >> (4 * idx)) & 16'h000F;
    chk("an_out", {12'h0, an_out}, {12'h0, e_an});
    if (!supp) chk("sseg_out", {8'h0, sseg_out}, {8'h0, e_sg});
    chk("digit_out", {12'h0, digit_out}, e_dig);
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, m_tick});
    @(posedge clk);
    m_tick = 0;
    if (t % (4 * DIV) == 4 * DIV - 1) begin
      if (ld) begin
        m_disp = val; m_tick = 1; m_pv = 0;
      end else if (m_pv) begin
        m_disp = m_pend; m_tick = 1; m_pv = 0;
      end
    end else if (ld) begin
      m_pend = val; m_pv = 1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 4'h0, 8'($urandom));
  endtask

  task automatic run_to(input int p);
    while (t % (4 * DIV) != p) cycle(1'b0, 16'($urandom), 4'h0, 8'($urandom));
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    dp_in    = 4'h0;
    sseg_in  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an", {12'h0, an_out}, 16'h000F);
    chk("rst_sseg", {8'h0, sseg_out}, 16'h00FF);
    chk("rst_digit", {12'h0, digit_out}, 16'h0000);
    chk("rst_tick", {15'h0, frame_tick}, 16'h0000);
    rst_n = 1'b1;
    model_reset();

    // Release: first slot blank then digit 0 lit.
    run(DIV);

    // Load mid-frame; it appears at the next wrap.
    run_to(13);
    cycle(1'b1, 16'h1234, 4'h0, 8'($urandom));
    run(2 * 4 * DIV);

    // Decimal point merge on digit 1.
    run_to(0);
    for (int i = 0; i < 4 * DIV; i++) cycle(1'b0, 16'h0, 4'b0010, 8'hC0);

    // Two loads in one frame: the last wins, one tick.
    run_to(5);
    cycle(1'b1, 16'h1111, 4'h0, 8'($urandom));
    run(10);
    cycle(1'b1, 16'h2222, 4'h0, 8'($urandom));
    run(2 * 4 * DIV);

    // Load exactly on the boundary cycle.
    run_to(4 * DIV - 1);
    cycle(1'b1, 16'hABCD, 4'h0, 8'($urandom));
    run(4 * DIV);

    // Asynchronous reset during digit 2 ON.
    run_to(2 * DIV + 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {12'h0, an_out}, 16'h000F);
    chk("arst_sseg", {8'h0, sseg_out}, 16'h00FF);
    chk("arst_digit", {12'h0, digit_out}, 16'h0000);
    chk("arst_tick", {15'h0, frame_tick}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(4 * DIV + 8);

    // Leading zeros.
    run_to(9);
    cycle(1'b1, 16'h0042, 4'h0, 8'($urandom));
    run(2 * 4 * DIV);
    for (int i = 0; i < 4 * DIV; i++) cycle(1'b0, 16'h0, 4'b1000, 8'($urandom));

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] mask;
      case ($urandom % 4)
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      cycle(($urandom % 12) == 0, 16'($urandom) & mask,
            (($urandom % 4) == 0) ? 4'($urandom) : 4'h0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
